toggle_activity_counter: RTL and testbench
==========================================

// Module: toggle_activity_counter
// PURPOSE
//  Downstream consumer of the mux4x1 select path. Samples the mux output bit,
//  counts its transitions (0->1 and 1->0) over a programmable window of clock
//  cycles, and returns the toggle count tagged with the mux select under test.
//  The result is the raw switching-activity figure the power estimator
//  aggregates. The result interface uses a valid/ready handshake.
// PARAMETERS
//  CNT_W  16  width of the toggle count result
//  WIN_W  16  width of the window length (cycles)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      1-cycle pulse: begin a measurement window (honoured only in IDLE)
//  win_len    in   WIN_W  window length N in compare cycles, sampled with start
//  sel_in     in   2      mux select under test, sampled with start
//  sig_in     in   1      mux4x1 output bit being measured
//  busy       out  1      high in ARM/COUNT/HOLD
//  res_valid  out  1      result available (high in HOLD)
//  res_ready  in   1      consumer accepts the result
//  res_count  out  CNT_W  toggles counted in the window
//  res_sel    out  2      sel_in captured at start
//  res_ovf    out  1      the count exceeded 2^CNT_W-1 during the window
// BEHAVIOUR
//  - Reset (asynchronous, rst_n=0): state=IDLE. busy, res_valid, res_count,
//    res_sel and res_ovf are all 0. Internal remaining-count and prev-sample
//    registers are 0.
//  - FSM states: IDLE -> ARM -> COUNT -> HOLD -> IDLE.
//    IDLE: start=1 latches win_len and sel_in, clears count and ovf.
//      If win_len!=0, go to ARM. If win_len==0, go directly to HOLD with count=0.
//    ARM: one cycle. prev <= sig_in. No toggle is counted. Go to COUNT.
//    COUNT: each cycle, toggle = sig_in ^ prev; prev <= sig_in;
//      count += toggle; remaining -= 1. When remaining==1 on this edge, go to HOLD.
//    HOLD: res_valid=1. res_count, res_sel and res_ovf stay stable.
//      The handshake completes on res_valid & res_ready, then go to IDLE.
//      The outputs keep their last values in IDLE until the next start.
//  - Latency: with start sampled at edge E0, res_valid rises after edge E(N+1).
//    This holds for N>=1. For N=0, res_valid rises after E0.
//  - start is ignored outside IDLE. There is no restart while busy.
//  - res_ready is ignored outside HOLD. In HOLD, res_ready held high gives a
//    1-cycle res_valid pulse.
//  - When start and a handshake coincide in HOLD, start is ignored.
//  - Every toggle in COUNT is counted, including on the last window cycle.
//  - Overflow: the first increment beyond all-ones sets res_ovf (sticky until
//    the next start).
//  - sig_in must already be synchronous to clk. No synchronizer is included.
// CONFIGURATION
//  - ACT_CNT_SAT_EN defined: the count saturates at all-ones. Once saturated,
//    further toggles do not change it. res_ovf is set on the first attempted
//    increment past saturation.
//  - ACT_CNT_SAT_EN undefined: the count wraps modulo 2^CNT_W. res_ovf is set
//    on the wrap.
// STRUCTURE
//  - act_defs.vh (shared include): state encodings ST_IDLE=2'd0, ST_ARM=2'd1,
//    ST_COUNT=2'd2, ST_HOLD=2'd3. It is also used by the estimator's
//    aggregation stage.
//  - Sub-module sig_toggle_det: holds the prev register and the XOR.
//    Ports: clk, rst_n, en, load, d, toggle.
//    load=1 captures d without asserting toggle (ARM).
//    en=1 outputs toggle=d^prev and updates prev (COUNT).
//  - The FSM, the remaining-count down counter, and the result registers live
//    in the top module.
// TESTING
//  1. Reset mid-COUNT (rst_n low for 1 cycle at cycle 5 of a 10-cycle window)
//     -> IDLE immediately; busy=0, res_valid=0, res_count=0, res_ovf=0.
//  2. win_len=8, sel_in=2'b10, sig_in alternating every cycle from ARM
//     -> res_valid after E9, res_count=8, res_sel=2'b10, res_ovf=0.
//  3. win_len=5, sig_in held 1 -> res_count=0.
//     win_len=0 -> res_valid after E0, res_count=0.
//  4. CNT_W=3, win_len=12, alternating sig_in
//     -> res_ovf=1 and res_count=7 with ACT_CNT_SAT_EN,
//        res_count=4 (12 mod 8) without it.
//  5. res_ready held low 20 cycles in HOLD, start pulsed meanwhile
//     -> outputs stable, start ignored. res_ready=1 -> one handshake, IDLE next.
//  6. Back-to-back: start in the cycle after the handshake
//     -> the new window runs. The count and ovf from the previous window are cleared.

Source files
------------

// File: rtl/toggle_activity_counter_pkg.sv
// Shared state encodings for the switching-activity counter and its estimator peers.
// Used by toggle_activity_counter (optional build macro: ACT_CNT_SAT_EN).
package toggle_activity_counter_pkg;

  // Encodings are fixed: the estimator's aggregation stage decodes them too.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StCount = 2'd2,
    StHold  = 2'd3
  } act_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/sig_toggle_det.sv
// Transition detector: remembers the previous sample and flags a change against it.
// load primes the history without flagging; en compares and advances it.
module sig_toggle_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  logic d,
  output logic toggle
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else if (load || en) begin
      prev_q <= d;
    end
  end

  assign toggle = en & (d ^ prev_q);

endmodule

// File: rtl/toggle_activity_counter.sv
// Counts transitions of the mux output over a programmed window and hands the figure out
// via valid/ready. Define ACT_CNT_SAT_EN to saturate the count instead of wrapping.
module toggle_activity_counter
  import toggle_activity_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [1:0]       sel_in,
  input  logic             sig_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [1:0]       res_sel,
  output logic             res_ovf
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [WIN_W-1:0] WinOne = WIN_W'(1);

  act_state_e       state_q;
  logic [WIN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic             ovf_q;
  logic             busy_q;
  logic             valid_q;

  logic det_en;
  logic det_load;
  logic toggle;

  assign det_load = (state_q == StArm);
  assign det_en   = (state_q == StCount);

  sig_toggle_det u_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (det_en),
    .load   (det_load),
    .d      (sig_in),
    .toggle (toggle)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sel_q  <= sel_in;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            rem_q  <= win_len;
            busy_q <= 1'b1;
            // An empty window has nothing to sample: report zero straight away.
            if (win_len == '0) begin
              state_q <= StHold;
              valid_q <= 1'b1;
            end else begin
              state_q <= StArm;
            end
          end
        end
        StArm: begin
          state_q <= StCount;
        end
        StCount: begin
          if (toggle) begin
`ifdef ACT_CNT_SAT_EN
            if (&cnt_q) begin
              ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
`else
            if (&cnt_q) begin
              ovf_q <= 1'b1;
            end
            cnt_q <= cnt_q + CntOne;
`endif
          end
          rem_q <= rem_q - WinOne;
          if (rem_q == WinOne) begin
            state_q <= StHold;
            valid_q <= 1'b1;
          end
        end
        StHold: begin
          // A start arriving with the handshake is dropped; only IDLE accepts it.
          if (res_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_count = cnt_q;
  assign res_sel   = sel_q;
  assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Directed bench for toggle_activity_counter: a 16-bit and a 3-bit counter share stimulus.
module tb_toggle_activity_counter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] win_len;
  logic [1:0]  sel_in;
  logic        sig_in;
  logic        res_ready;

  logic        busy;
  logic        res_valid;
  logic [15:0] res_count;
  logic [1:0]  res_sel;
  logic        res_ovf;

  logic        busy_s;
  logic        res_valid_s;
  logic [2:0]  res_count_s;
  logic [1:0]  res_sel_s;
  logic        res_ovf_s;

  int n_checks;
  int n_fail;

`ifdef ACT_CNT_SAT_EN
  localparam int SmallExp12 = 7;
`else
  localparam int SmallExp12 = 4;
`endif

  toggle_activity_counter #(
    .CNT_W (16),
    .WIN_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_len   (win_len),
    .sel_in    (sel_in),
    .sig_in    (sig_in),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_sel   (res_sel),
    .res_ovf   (res_ovf)
  );

  toggle_activity_counter #(
    .CNT_W (3),
    .WIN_W (16)
  ) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_len   (win_len),
    .sel_in    (sel_in),
    .sig_in    (sig_in),
    .busy      (busy_s),
    .res_valid (res_valid_s),
    .res_ready (res_ready),
    .res_count (res_count_s),
    .res_sel   (res_sel_s),
    .res_ovf   (res_ovf_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Entered and left at a falling edge. alt=1 flips sig_in every edge from ARM on.
  task automatic run_window(input int n, input logic [1:0] sel, input bit alt);
    start   = 1'b1;
    win_len = n[15:0];
    sel_in  = sel;
    sig_in  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("start_cnt_clr", 32'(res_count), 0);
    check_eq("start_ovf_clr", 32'(res_ovf), 0);
    check_eq("start_ovf_clr_s", 32'(res_ovf_s), 0);
    check_eq("start_sel", 32'(res_sel), 32'(sel));
    check_eq("start_busy", 32'(busy), 1);
    if (n == 0) begin
      check_eq("valid_n0", 32'(res_valid), 1);
      return;
    end
    for (int k = 1; k <= n + 1; k++) begin
      sig_in = alt ? k[0] : 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (k == n) check_eq("valid_early", 32'(res_valid), 0);
      if (k == n + 1) check_eq("valid_lat", 32'(res_valid), 1);
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("valid_drop", 32'(res_valid), 0);
    check_eq("busy_drop", 32'(busy), 0);
  endtask

  initial begin
    bit stable_ok;
    n_checks  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    win_len   = '0;
    sel_in    = 2'b00;
    sig_in    = 1'b0;
    res_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_valid", 32'(res_valid), 0);
    check_eq("rst_count", 32'(res_count), 0);
    check_eq("rst_sel", 32'(res_sel), 0);
    check_eq("rst_ovf", 32'(res_ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a 10-cycle window.
    start   = 1'b1;
    win_len = 16'd10;
    sel_in  = 2'b11;
    sig_in  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sig_in = k[0];
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("mid_count", 32'(res_count), 4);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_valid", 32'(res_valid), 0);
    check_eq("arst_count", 32'(res_count), 0);
    check_eq("arst_ovf", 32'(res_ovf), 0);
    check_eq("arst_sel", 32'(res_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(busy), 0);

    // Alternating input, 8-cycle window.
    run_window(8, 2'b10, 1'b1);
    check_eq("alt8_count", 32'(res_count), 8);
    check_eq("alt8_sel", 32'(res_sel), 2);
    check_eq("alt8_ovf", 32'(res_ovf), 0);
    accept();

    // Static input, then the 1-cycle and 0-cycle window boundaries.
    run_window(5, 2'b01, 1'b0);
    check_eq("hold5_count", 32'(res_count), 0);
    accept();
    run_window(1, 2'b00, 1'b1);
    check_eq("alt1_count", 32'(res_count), 1);
    accept();
    run_window(0, 2'b10, 1'b1);
    check_eq("win0_count", 32'(res_count), 0);
    accept();

    // 12 toggles: fits 16 bits, overflows the 3-bit counter.
    run_window(12, 2'b11, 1'b1);
    check_eq("alt12_count", 32'(res_count), 12);
    check_eq("alt12_ovf", 32'(res_ovf), 0);
    check_eq("small_count", 32'(res_count_s), 32'(SmallExp12));
    check_eq("small_ovf", 32'(res_ovf_s), 1);

    // Stall in HOLD with a stray start; the result must not move.
    stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      start   = (c == 5);
      win_len = 16'd2;
      sel_in  = 2'b00;
      sig_in  = c[0];
      @(posedge clk);
      @(negedge clk);
      if (res_valid !== 1'b1 || busy !== 1'b1 || res_count !== 16'd12 || res_sel !== 2'b11 ||
          res_ovf !== 1'b0 || res_count_s !== 3'(SmallExp12) || res_ovf_s !== 1'b1) begin
        stable_ok = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("hold_stable", 32'(stable_ok), 1);

    // Start coinciding with the handshake is dropped.
    res_ready = 1'b1;
    start     = 1'b1;
    win_len   = 16'd6;
    sel_in    = 2'b01;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    check_eq("coinc_valid", 32'(res_valid), 0);
    check_eq("coinc_busy", 32'(busy), 0);
    check_eq("coinc_sel", 32'(res_sel), 3);

    // Back-to-back start: previous count and overflow are cleared.
    run_window(4, 2'b01, 1'b0);
    check_eq("b2b_count", 32'(res_count), 0);
    check_eq("b2b_count_s", 32'(res_count_s), 0);
    check_eq("b2b_ovf_s", 32'(res_ovf_s), 0);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
